// File: rtl/lfsr_pkg.sv
// lfsr_pkg: mode encodings, default seed and the single-step LFSR function
package lfsr_pkg;

    localparam logic LFSR_MODE_FIB = 1'b0;
    localparam logic LFSR_MODE_GAL = 1'b1;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h19;

    // State and taps arrive zero-extended to 32 bits; bits above width are ignored
    function automatic logic [31:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps,
                                              input logic mode, input int width);
        logic [31:0] mask;
        logic [31:0] shifted;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        shifted = (state << 1) & mask;
        return (mode == LFSR_MODE_GAL) ? (shifted ^ (state[5'(width - 1)] ? (taps & mask) : 32'd0))
                                       : (shifted | {31'd0, ^(state & taps & mask)});
    endfunction

endpackage

// File: rtl/lfsr_step_chain.sv
// lfsr_step_chain: STEPS single LFSR steps unrolled combinationally
module lfsr_step_chain
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEPS = 1
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    input  logic             mode,
    output logic [WIDTH-1:0] next_state
);

    logic [WIDTH-1:0] s;

    always_comb begin
        s = state;
        for (int i = 0; i < STEPS; i++) s = WIDTH'(lfsr_step(32'(s), 32'(taps), mode, WIDTH));
        next_state = s;
    end

endmodule

// File: rtl/lfsr_prng_gen.sv
// lfsr_prng_gen: parametrised LFSR PRNG on a valid/ready stream; LFSR_PERIOD_MON_EN adds a period monitor
module lfsr_prng_gen
    import lfsr_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter int          STEPS        = 1,
    parameter logic [31:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] taps,
    input  logic             mode,
    input  logic             enable,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
`ifdef LFSR_PERIOD_MON_EN
    output logic             period_hit,
    output logic [WIDTH-1:0] period_len,
`endif
    output logic             recovered
);

    localparam logic [WIDTH-1:0] SEED_W = DEFAULT_SEED[WIDTH-1:0];

    logic [WIDTH-1:0] state_q, state_d, out_data_q, out_data_d, next_state;
    logic             out_valid_q, out_valid_d, recovered_q, recovered_d;
    logic             adv, restart;

    lfsr_step_chain #(.WIDTH(WIDTH), .STEPS(STEPS)) u_chain (
        .state      (state_q),
        .taps       (taps),
        .mode       (mode),
        .next_state (next_state)
    );

    assign adv     = enable && (!out_valid_q || out_ready);
    // A zero state would lock up; it is replaced instead of being emitted
    assign restart = adv && (state_q == '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        recovered_d = 1'b0;
        if (load) begin
            state_d     = (seed == '0) ? SEED_W : seed;
            out_valid_d = 1'b0;
            recovered_d = (seed == '0);
        end else if (restart) begin
            state_d     = SEED_W;
            out_valid_d = out_valid_q && !out_ready;
            recovered_d = 1'b1;
        end else if (adv) begin
            state_d     = next_state;
            out_data_d  = state_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEED_W;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            recovered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            recovered_q <= recovered_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign recovered = recovered_q;

`ifdef LFSR_PERIOD_MON_EN
    logic [WIDTH-1:0] start_state_q, start_state_d, adv_cnt_q, adv_cnt_d, cnt_inc;
    logic [WIDTH-1:0] period_len_q, period_len_d;
    logic             period_hit_q, period_hit_d, capture;

    assign capture = load || restart;
    assign cnt_inc = (&adv_cnt_q) ? adv_cnt_q : adv_cnt_q + WIDTH'(1);

    // The period closes when the state about to be entered is the captured start
    always_comb begin
        start_state_d = capture ? state_d : start_state_q;
        adv_cnt_d     = adv_cnt_q;
        period_len_d  = period_len_q;
        period_hit_d  = 1'b0;
        if (capture) begin
            adv_cnt_d = '0;
        end else if (adv) begin
            period_hit_d = (next_state == start_state_q);
            adv_cnt_d    = period_hit_d ? '0 : cnt_inc;
            period_len_d = period_hit_d ? cnt_inc : period_len_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_state_q <= SEED_W;
            adv_cnt_q     <= '0;
            period_len_q  <= '0;
            period_hit_q  <= 1'b0;
        end else begin
            start_state_q <= start_state_d;
            adv_cnt_q     <= adv_cnt_d;
            period_len_q  <= period_len_d;
            period_hit_q  <= period_hit_d;
        end
    end

    assign period_hit = period_hit_q;
    assign period_len = period_len_q;
`endif

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// tb_lfsr_prng_gen: random and directed checks of lfsr_prng_gen (STEPS=1 and STEPS=8) against a word-level model
module tb_lfsr_prng_gen;

    localparam int W    = 8;
    localparam int SEED = 'h19;

    logic         clk = 1'b0;
    logic         rst, load, enable, out_ready, mode;
    logic [W-1:0] seed, taps;
    logic         v1, v8, r1, r8;
    logic [W-1:0] d1, d8;
`ifdef LFSR_PERIOD_MON_EN
    logic         h1, h8;
    logic [W-1:0] l1, l8;
`endif

    int errors = 0;
    int checks = 0;

    int           ms[2];
    bit           ev[2], er[2], ph[2];
    logic [W-1:0] ed[2], pl[2];
    int           pc[2], ps[2];

    always #5 clk = ~clk;

    lfsr_prng_gen #(.WIDTH(W), .STEPS(1)) dut (
        .clk(clk), .rst(rst), .load(load), .seed(seed), .taps(taps), .mode(mode),
        .enable(enable), .out_ready(out_ready), .out_valid(v1), .out_data(d1),
`ifdef LFSR_PERIOD_MON_EN
        .period_hit(h1), .period_len(l1),
`endif
        .recovered(r1)
    );

    lfsr_prng_gen #(.WIDTH(W), .STEPS(8)) dut8 (
        .clk(clk), .rst(rst), .load(load), .seed(seed), .taps(taps), .mode(mode),
        .enable(enable), .out_ready(out_ready), .out_valid(v8), .out_data(d8),
`ifdef LFSR_PERIOD_MON_EN
        .period_hit(h8), .period_len(l8),
`endif
        .recovered(r8)
    );

    function automatic int step1(int s, int t, logic m);
        int top = (s >= (1 << (W - 1))) ? 1 : 0;
        int sh  = (s * 2) % (1 << W);
        if (m) return top ? (sh ^ t) : sh;
        return sh + ($countones(s & t) % 2);
    endfunction

    function automatic int adv_n(int s, int n);
        for (int i = 0; i < n; i++) s = step1(s, int'(taps), mode);
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k] = SEED; ev[k] = 0; er[k] = 0; ed[k] = '0;
            ps[k] = SEED; pc[k] = 0; pl[k] = '0; ph[k] = 0;
        end
    endtask

    // Predicts register contents after the next clock edge from the inputs now applied
    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            int nxt;
            bit adv, was_v;
            was_v = ev[k];
            adv   = enable && (!was_v || out_ready);
            er[k] = 0;
            ph[k] = 0;
            if (load) begin
                ms[k] = (seed == 0) ? SEED : int'(seed);
                ev[k] = 0;
                er[k] = (seed == 0);
                ps[k] = ms[k]; pc[k] = 0;
            end else if (adv && ms[k] == 0) begin
                ms[k] = SEED; er[k] = 1; ev[k] = 0;
                ps[k] = ms[k]; pc[k] = 0;
            end else if (adv) begin
                nxt   = adv_n(ms[k], (k == 0) ? 1 : 8);
                ed[k] = W'(ms[k]);
                ev[k] = 1;
                if (nxt == ps[k]) begin
                    ph[k] = 1; pl[k] = W'((pc[k] + 1 > 255) ? 255 : pc[k] + 1); pc[k] = 0;
                end else begin
                    pc[k] = (pc[k] + 1 > 255) ? 255 : pc[k] + 1;
                end
                ms[k] = nxt;
            end else if (was_v && out_ready) begin
                ev[k] = 0;
            end
        end
    endtask

    task automatic cyc();
        model_tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 0; seed = '0; taps = '0; mode = 0; enable = 0; out_ready = 0;
        model_reset();
        @(negedge clk);
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", v1); end
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", d1); end
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL reset_recovered: got %0b want 0", r1); end
        checks++; if (v8 !== 1'b0 || r8 !== 1'b0) begin errors++; $display("FAIL reset_steps8: valid %0b rec %0b want 0 0", v8, r8); end
`ifdef LFSR_PERIOD_MON_EN
        checks++; if (l1 !== 8'h00 || h1 !== 1'b0) begin errors++; $display("FAIL reset_period: len %h hit %0b want 00 0", l1, h1); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_fib_seq();
        logic [W-1:0] tab [4];
        tab[0] = 8'h19; tab[1] = 8'h32; tab[2] = 8'h64; tab[3] = 8'hC9;
        mode = 0; taps = 8'hB8; out_ready = 1; enable = 1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            checks++; if (v1 !== 1'b1 || d1 !== tab[i]) begin errors++; $display("FAIL fib_word[%0d]: got v=%0b %h want v=1 %h", i, v1, d1, tab[i]); end
            checks++; if (v8 !== 1'b1 || d8 !== ed[1]) begin errors++; $display("FAIL fib_steps8[%0d]: got v=%0b %h want v=1 %h", i, v8, d8, ed[1]); end
            cyc();
        end
    endtask

    task automatic test_galois();
        logic [W-1:0] tab [5];
        tab[0] = 8'h19; tab[1] = 8'h32; tab[2] = 8'h64; tab[3] = 8'hC8; tab[4] = 8'h8D;
        enable = 0; mode = 1; taps = 8'h1D; load = 1; seed = 8'h19;
        cyc();
        load = 0;
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL gal_load_flush: got v=%0b want 0", v1); end
        enable = 1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            checks++; if (v1 !== 1'b1 || d1 !== tab[i]) begin errors++; $display("FAIL gal_word[%0d]: got v=%0b %h want v=1 %h", i, v1, d1, tab[i]); end
            checks++; if (d8 !== ed[1]) begin errors++; $display("FAIL gal_steps8[%0d]: got %h want %h", i, d8, ed[1]); end
            cyc();
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        mode = 0; taps = 8'hB8; load = 1; seed = 8'h19; enable = 1; out_ready = 1;
        cyc();
        load = 0;
        for (int i = 0; i < 14; i++) begin
            out_ready = !(i >= 4 && i < 9);
            if (i == 4) held = ed[0];
            cyc();
            if (i >= 4 && i < 9) begin
                checks++; if (v1 !== 1'b1 || d1 !== held) begin errors++; $display("FAIL stall_hold[%0d]: got v=%0b %h want v=1 %h", i, v1, d1, held); end
            end
            checks++; if (v1 !== ev[0] || d1 !== ed[0]) begin errors++; $display("FAIL stall_seq[%0d]: got v=%0b %h want v=%0b %h", i, v1, d1, ev[0], ed[0]); end
            checks++; if (v8 !== ev[1] || d8 !== ed[1]) begin errors++; $display("FAIL stall_steps8[%0d]: got v=%0b %h want v=%0b %h", i, v8, d8, ev[1], ed[1]); end
        end
    endtask

    task automatic test_recovery();
        int got_rec, want_rec;
        enable = 0; load = 1; seed = 8'h00;
        cyc();
        load = 0;
        checks++; if (r1 !== 1'b1 || v1 !== 1'b0) begin errors++; $display("FAIL rec_load_zero: rec %0b v %0b want 1 0", r1, v1); end
        enable = 1; out_ready = 1; mode = 0; taps = 8'hB8;
        cyc();
        checks++; if (r1 !== 1'b0 || v1 !== 1'b1 || d1 !== 8'h19) begin errors++; $display("FAIL rec_first_word: rec %0b v %0b %h want 0 1 19", r1, v1, d1); end
        taps = 8'h00;
        got_rec = 0; want_rec = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            got_rec += r1; want_rec += er[0];
            checks++; if (v1 && d1 === 8'h00) begin errors++; $display("FAIL rec_zero_emitted[%0d]: got %h want nonzero", i, d1); end
            checks++; if (r1 !== er[0] || v1 !== ev[0] || (ev[0] && d1 !== ed[0])) begin errors++; $display("FAIL rec_taps0[%0d]: rec %0b v %0b %h want %0b %0b %h", i, r1, v1, d1, er[0], ev[0], ed[0]); end
            checks++; if (r8 !== er[1] || v8 !== ev[1] || (ev[1] && d8 !== ed[1])) begin errors++; $display("FAIL rec_steps8[%0d]: rec %0b v %0b %h want %0b %0b %h", i, r8, v8, d8, er[1], ev[1], ed[1]); end
        end
        checks++; if (got_rec < 1 || got_rec !== want_rec) begin errors++; $display("FAIL rec_pulse_count: got %0d want %0d (nonzero)", got_rec, want_rec); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 64 == 0) begin taps = W'($urandom); mode = $urandom_range(0, 1); end
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1);
            load      = ($urandom_range(0, 39) == 0);
            seed      = ($urandom_range(0, 2) == 0) ? 8'h00 : W'($urandom);
            cyc();
            checks++; if (v1 !== ev[0] || r1 !== er[0]) begin errors++; $display("FAIL rand_ctl[%0d]: v %0b rec %0b want %0b %0b", i, v1, r1, ev[0], er[0]); end
            checks++; if (ev[0] && d1 !== ed[0]) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, d1, ed[0]); end
            checks++; if (v8 !== ev[1] || r8 !== er[1] || (ev[1] && d8 !== ed[1])) begin errors++; $display("FAIL rand_steps8[%0d]: v %0b rec %0b %h want %0b %0b %h", i, v8, r8, d8, ev[1], er[1], ed[1]); end
        end
        load = 0;
    endtask

    task automatic test_reset_mid_stall();
        mode = 0; taps = 8'hB8; load = 1; seed = 8'h5A; enable = 1; out_ready = 1;
        cyc();
        load = 0;
        repeat (3) cyc();
        out_ready = 0;
        repeat (2) cyc();
        #2 rst = 1'b1;
        #1;
        checks++; if (v1 !== 1'b0 || v8 !== 1'b0) begin errors++; $display("FAIL rst_async_valid: v1 %0b v8 %0b want 0 0", v1, v8); end
        checks++; if (d1 !== 8'h00 || d8 !== 8'h00) begin errors++; $display("FAIL rst_async_data: d1 %h d8 %h want 00 00", d1, d8); end
        model_reset();
        @(negedge clk);
        rst = 1'b0; out_ready = 1;
        cyc();
        checks++; if (v1 !== 1'b1 || d1 !== 8'h19) begin errors++; $display("FAIL rst_restart: v %0b %h want 1 19", v1, d1); end
        checks++; if (v8 !== 1'b1 || d8 !== 8'h19) begin errors++; $display("FAIL rst_restart8: v %0b %h want 1 19", v8, d8); end
        cyc();
        checks++; if (d1 !== ed[0] || d8 !== ed[1]) begin errors++; $display("FAIL rst_second: %h %h want %h %h", d1, d8, ed[0], ed[1]); end
    endtask

`ifdef LFSR_PERIOD_MON_EN
    task automatic test_period_mon();
        int first = -1;
        mode = 0; taps = 8'hB8; load = 1; seed = 8'h19; enable = 1; out_ready = 1;
        cyc();
        load = 0;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (h1 === 1'b1 && first < 0) first = i;
            checks++; if (h1 !== ph[0] || h8 !== ph[1]) begin errors++; $display("FAIL period_hit[%0d]: got %0b %0b want %0b %0b", i, h1, h8, ph[0], ph[1]); end
        end
        checks++; if (first != 255) begin errors++; $display("FAIL period_first_hit: got %0d want 255", first); end
        checks++; if (l1 !== 8'd255 || l1 !== pl[0]) begin errors++; $display("FAIL period_len: got %0d want 255", l1); end
        checks++; if (l8 !== 8'd255 || l8 !== pl[1]) begin errors++; $display("FAIL period_len8: got %0d want 255", l8); end
    endtask
`endif

    initial begin
        test_reset();
        test_fib_seq();
        test_galois();
        test_stall();
        test_recovery();
        test_random();
        test_reset_mid_stall();
`ifdef LFSR_PERIOD_MON_EN
        test_period_mon();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
